// File: rtl/adc_frame_deserializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : adc_frame_deserializer_if
//  Description : Bundle of the serial-ADC deserializer data path signals.
//                The ADC side (testbench or upstream wrapper) uses the
//                master modport. It drives serial data, frame and enable,
//                and observes the parallel word outputs. The deserializer
//                core uses the slave modport.
//  Ports       : data_in     - serial bits, one per channel
//                frame_in    - ADC frame marker, rising edge = word start
//                enable      - 0 holds the core idle
//                deser_out   - parallel words, channel i at [i*BITS +: BITS]
//                deser_valid - one-cycle strobe, deser_out just updated
//                locked      - frame alignment established
//                frame_err   - one-cycle pulse on a framing error while locked
//                err_count   - saturating count of locked-state errors
//  Revision    : 1.0 - initial release
// ============================================================================
interface adc_frame_deserializer_if #(
    parameter int NUM_CH = 4,
    parameter int BITS   = 10
);
    logic [NUM_CH-1:0]      data_in;
    logic                   frame_in;
    logic                   enable;
    logic [NUM_CH*BITS-1:0] deser_out;
    logic                   deser_valid;
    logic                   locked;
    logic                   frame_err;
    logic [7:0]             err_count;

    modport master (
        output data_in,
        output frame_in,
        output enable,
        input  deser_out,
        input  deser_valid,
        input  locked,
        input  frame_err,
        input  err_count
    );

    modport slave (
        input  data_in,
        input  frame_in,
        input  enable,
        output deser_out,
        output deser_valid,
        output locked,
        output frame_err,
        output err_count
    );
endinterface
`default_nettype wire

// File: rtl/adc_frame_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_frame_deserializer
//  Description : Multi-channel serial ADC deserializer with frame alignment.
//                Every channel shifts one bit per data_clk rising edge. The
//                ADC frame signal is edge-detected and tracked by a
//                HUNT / ALIGN / LOCKED state machine. Once LOCK_FRAMES
//                consecutive frame edges arrive exactly BITS cycles apart,
//                complete words of all channels are presented on deser_out
//                together with a one-cycle deser_valid strobe.
//  Ports       : data_clk - sole clock, one serial bit per channel per edge
//                reset    - asynchronous, active-high
//                bus      - adc_frame_deserializer_if.slave (data_in,
//                           frame_in, enable, deser_out, deser_valid, locked,
//                           frame_err, err_count)
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_frame_deserializer #(
    parameter int NUM_CH      = 4,   // 1..16
    parameter int BITS        = 10,  // 4..16
    parameter int LOCK_FRAMES = 4,   // 1..15
    parameter int MSB_FIRST   = 1    // 1: first serial bit is the word MSB
) (
    input  wire                     data_clk,
    input  wire                     reset,
    adc_frame_deserializer_if.slave bus
);

    localparam int                c_CNT_W = $clog2(BITS);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BITS - 1);
    localparam logic [3:0]        c_LOCK  = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;   // index of the bit sampled this cycle
    logic [3:0]           good_q, good_d; // consecutive on-time edges in ALIGN
    logic                 frame_q;

    // Output registers
    logic [NUM_CH*BITS-1:0] deser_q;
    logic                   valid_q;
    logic                   err_q;
    logic                   locked_q;
    logic [7:0]             errcnt_q;

    // Combinational helpers
    logic                   w_edge;
    logic                   w_expected;
    logic [c_CNT_W-1:0]     w_cnt_inc;
    logic                   w_load;
    logic                   w_err;
    logic [NUM_CH*BITS-1:0] w_word;     // every channel's register after this shift

    assign w_edge     = bus.frame_in & ~frame_q;
    // The previous cycle carried the last bit of a word, so a new word must
    // start now: this is the only cycle on which a frame edge is legal.
    assign w_expected = (cnt_q == c_LAST);
    assign w_cnt_inc  = w_expected ? '0 : cnt_q + c_CNT_W'(1);

    // ------------------------------------------------------------------
    // Per-channel shift registers
    // ------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [BITS-1:0] sr_q;
        logic [BITS-1:0] sr_d;

        if (MSB_FIRST != 0) begin : g_msb
            // Oldest bit walks up to the MSB after BITS shifts.
            assign sr_d = {sr_q[BITS-2:0], bus.data_in[c]};
        end else begin : g_lsb
            // Oldest bit walks down to bit 0 after BITS shifts.
            assign sr_d = {bus.data_in[c], sr_q[BITS-1:1]};
        end

        always_ff @(posedge data_clk or posedge reset) begin
            if (reset) begin
                sr_q <= '0;
            end else if (bus.enable) begin
                sr_q <= sr_d;
            end
        end

        // The word is taken from the next-state value so that the bit
        // sampled on the loading edge is already part of it.
        assign w_word[c*BITS +: BITS] = sr_d;
    end

    // ------------------------------------------------------------------
    // Frame tracking state machine: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = w_cnt_inc;
        good_d  = good_q;
        w_load  = 1'b0;
        w_err   = 1'b0;

        if (!bus.enable) begin
            state_d = ST_HUNT;
            good_d  = '0;
            cnt_d   = cnt_q;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    if (w_edge) begin
                        state_d = ST_ALIGN;
                        cnt_d   = '0;
                        good_d  = '0;
                    end
                end

                ST_ALIGN: begin
                    if (w_edge && w_expected) begin
                        cnt_d  = '0;
                        good_d = good_q + 4'd1;
                        if ((good_q + 4'd1) == c_LOCK) begin
                            state_d = ST_LOCKED;
                        end
                    end else if (w_edge) begin
                        // Early edge: treat it as the start of a new word.
                        cnt_d  = '0;
                        good_d = '0;
                    end else if (w_expected) begin
                        state_d = ST_HUNT;
                        good_d  = '0;
                    end
                end

                ST_LOCKED: begin
                    if (w_edge && w_expected) begin
                        cnt_d = '0;
                    end else if (w_edge) begin
                        // Truncated word is dropped; realign on this edge.
                        state_d = ST_ALIGN;
                        cnt_d   = '0;
                        good_d  = '0;
                        w_err   = 1'b1;
                    end else if (w_expected) begin
                        state_d = ST_HUNT;
                        good_d  = '0;
                        w_err   = 1'b1;
                    end else begin
                        // Last bit of the word sampled on this edge.
                        w_load = (cnt_d == c_LAST);
                    end
                end

                default: begin
                    state_d = ST_HUNT;
                    cnt_d   = '0;
                    good_d  = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame tracking state machine: registers
    // ------------------------------------------------------------------
    always_ff @(posedge data_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_HUNT;
            cnt_q   <= '0;
            good_q  <= '0;
            // Reset high so a frame already high at release is not an edge.
            frame_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            good_q  <= good_d;
            frame_q <= bus.frame_in;
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge data_clk or posedge reset) begin
        if (reset) begin
            deser_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            errcnt_q <= '0;
        end else begin
            valid_q  <= w_load;
            err_q    <= w_err;
            locked_q <= (state_d == ST_LOCKED);
            if (w_load) begin
                deser_q <= w_word;
            end
            if (w_err && (errcnt_q != 8'hFF)) begin
                errcnt_q <= errcnt_q + 8'd1;
            end
        end
    end

    assign bus.deser_out   = deser_q;
    assign bus.deser_valid = valid_q;
    assign bus.frame_err   = err_q;
    assign bus.locked      = locked_q;
    assign bus.err_count   = errcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_frame_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_frame_deserializer
//  Description : Directed self-checking bench. DUT A uses default parameters
//                (4 ch, 10 bit, MSB first). DUT B uses 2 ch, 12 bit,
//                LSB first. Frames are driven one serial word at a time. The
//                bench tracks per-frame counts of valid and error pulses and
//                compares them with hand-derived values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_frame_deserializer;

    localparam int A_CH = 4, A_BITS = 10;
    localparam int B_CH = 2, B_BITS = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adc_frame_deserializer_if #(.NUM_CH(A_CH), .BITS(A_BITS)) bus_a ();
    adc_frame_deserializer_if #(.NUM_CH(B_CH), .BITS(B_BITS)) bus_b ();

    adc_frame_deserializer #(
        .NUM_CH(A_CH), .BITS(A_BITS), .LOCK_FRAMES(4), .MSB_FIRST(1)
    ) u_dut_a (
        .data_clk (clk),
        .reset    (rst),
        .bus      (bus_a)
    );

    adc_frame_deserializer #(
        .NUM_CH(B_CH), .BITS(B_BITS), .LOCK_FRAMES(4), .MSB_FIRST(0)
    ) u_dut_b (
        .data_clk (clk),
        .reset    (rst),
        .bus      (bus_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Words per channel for the current frame
    logic [A_BITS-1:0] wa [A_CH];
    logic [B_BITS-1:0] wb [B_CH];

    // Per-frame observations
    int                    fa_valid, fa_err, fa_vpos;
    logic                  fa_lk0;
    logic [A_CH*A_BITS-1:0] fa_out;
    int                    fb_valid, fb_vpos;
    logic                  fb_lk0;
    logic [B_CH*B_BITS-1:0] fb_out;

    function automatic logic [A_CH*A_BITS-1:0] exp_a();
        return {wa[3], wa[2], wa[1], wa[0]};
    endfunction

    // One clock: inputs are already driven; returns at the next falling
    // edge with the outputs of that rising edge visible.
    task automatic step(input int j);
        @(posedge clk);
        @(negedge clk);
        if (bus_a.deser_valid) begin fa_valid++; fa_vpos = j; fa_out = bus_a.deser_out; end
        if (bus_a.frame_err) fa_err++;
        if (j == 0) fa_lk0 = bus_a.locked;
        if (bus_b.deser_valid) begin fb_valid++; fb_vpos = j; fb_out = bus_b.deser_out; end
        if (j == 0) fb_lk0 = bus_b.locked;
    endtask

    task automatic clear_a();
        fa_valid = 0; fa_err = 0; fa_vpos = -1;
    endtask

    // Send len bits of the current wa words, MSB first; frame high on the
    // first two bits when with_edge is set.
    task automatic send_a(input int len, input bit with_edge);
        clear_a();
        for (int j = 0; j < len; j++) begin
            bus_a.frame_in = with_edge && (j < 2);
            for (int c = 0; c < A_CH; c++) bus_a.data_in[c] = wa[c][A_BITS-1-j];
            step(j);
        end
    endtask

    task automatic send_b(input int len, input bit with_edge);
        fb_valid = 0; fb_vpos = -1;
        for (int j = 0; j < len; j++) begin
            bus_b.frame_in = with_edge && (j < 2);
            for (int c = 0; c < B_CH; c++) bus_b.data_in[c] = wb[c][j];
            step(j);
        end
    endtask

    int sum_v, sum_e;
    logic [A_CH*A_BITS-1:0] held;

    initial begin
        bus_a.enable = 1'b1; bus_a.frame_in = 1'b1; bus_a.data_in = '0;
        bus_b.enable = 1'b0; bus_b.frame_in = 1'b0; bus_b.data_in = '0;
        clear_a();
        fb_valid = 0; fb_vpos = -1; fa_lk0 = 1'b0; fb_lk0 = 1'b0;
        fa_out = '0; fb_out = '0;

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        check_eq("reset_outs_a", {bus_a.locked, bus_a.deser_valid, bus_a.frame_err,
                                  bus_a.err_count, bus_a.deser_out}, 64'd0);
        check_eq("reset_outs_b", {bus_b.locked, bus_b.deser_valid, bus_b.deser_out}, 64'd0);

        // Frame high across release: must not start alignment. The real first
        // edge then comes 10 cycles later, which a false edge would make
        // look on time and lock one frame early.
        rst = 1'b0;
        step(1);
        bus_a.frame_in = 1'b0;
        repeat (9) step(1);

        // ---------------- basic lock, MSB first ----------------
        wa = '{10'h2A5, 10'h15A, 10'h3C3, 10'h0F1};
        sum_v = 0;
        for (int f = 0; f < 4; f++) begin
            send_a(10, 1'b1);
            sum_v += fa_valid;
        end
        check_eq("prelock_locked", bus_a.locked, 1'b0);
        check_eq("prelock_valid", sum_v, 0);
        send_a(10, 1'b1);
        check_eq("lock_after_5th_edge", fa_lk0, 1'b1);
        check_eq("first_word_valids", fa_valid, 1);
        check_eq("first_word_pos", fa_vpos, 9);
        check_eq("first_word_ch0", fa_out[9:0], 10'h2A5);
        check_eq("first_word_all", fa_out, exp_a());

        wa = '{10'h155, 10'h0F0, 10'h30C, 10'h001};
        send_a(10, 1'b1);
        check_eq("second_word_valids", fa_valid, 1);
        check_eq("second_word_all", fa_out, exp_a());

        // ---------------- early edge while locked ----------------
        send_a(7, 1'b1);
        check_eq("trunc_valids", fa_valid, 0);
        check_eq("trunc_err_before_edge", fa_err, 0);
        wa = '{10'h3A1, 10'h222, 10'h0BD, 10'h1E7};
        send_a(10, 1'b1);
        check_eq("early_err_pulses", fa_err, 1);
        check_eq("early_unlock", fa_lk0, 1'b0);
        check_eq("early_valids", fa_valid, 0);
        check_eq("early_err_count", bus_a.err_count, 8'd1);
        sum_v = 0;
        for (int f = 0; f < 3; f++) begin
            send_a(10, 1'b1);
            sum_v += fa_valid;
        end
        check_eq("realign_valids", sum_v, 0);
        check_eq("realign_locked", bus_a.locked, 1'b0);
        send_a(10, 1'b1);
        check_eq("relock", fa_lk0, 1'b1);
        check_eq("relock_valids", fa_valid, 1);
        check_eq("relock_word", fa_out, exp_a());

        // ---------------- missing edge while locked ----------------
        send_a(10, 1'b0);
        check_eq("miss_err_pulses", fa_err, 1);
        check_eq("miss_unlock", fa_lk0, 1'b0);
        check_eq("miss_valids", fa_valid, 0);
        check_eq("miss_err_count", bus_a.err_count, 8'd2);

        // ---------------- error counter saturation ----------------
        for (int f = 0; f < 4; f++) send_a(10, 1'b1);  // HUNT->ALIGN, good=3
        sum_v = 0; sum_e = 0;
        for (int i = 0; i < 300; i++) begin
            send_a(7, 1'b1);                          // locking edge, cut short
            sum_v += fa_valid; sum_e += fa_err;
            for (int f = 0; f < 4; f++) begin
                send_a(10, 1'b1);                     // first one is the error
                sum_v += fa_valid; sum_e += fa_err;
            end
            if (i == 251) check_eq("err_count_254", bus_a.err_count, 8'd254);
        end
        check_eq("sat_err_pulses", sum_e, 300);
        check_eq("sat_valids", sum_v, 0);
        check_eq("sat_err_count", bus_a.err_count, 8'd255);

        // ---------------- enable dropped mid-word ----------------
        wa = '{10'h0AA, 10'h355, 10'h18C, 10'h2F0};
        send_a(10, 1'b1);
        check_eq("pre_disable_word", fa_out, exp_a());
        held = exp_a();
        wa = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};
        send_a(5, 1'b1);
        clear_a();
        bus_a.enable = 1'b0;
        bus_a.frame_in = 1'b0;
        repeat (3) step(1);
        check_eq("dis_locked", bus_a.locked, 1'b0);
        check_eq("dis_valids", fa_valid, 0);
        check_eq("dis_errs", fa_err, 0);
        check_eq("dis_out_held", bus_a.deser_out, held);
        check_eq("dis_cnt_held", bus_a.err_count, 8'd255);
        bus_a.enable = 1'b1;
        wa = '{10'h123, 10'h234, 10'h345, 10'h056};
        sum_v = 0;
        for (int f = 0; f < 4; f++) begin send_a(10, 1'b1); sum_v += fa_valid; end
        send_a(10, 1'b1);
        check_eq("reen_prelock_valids", sum_v, 0);
        check_eq("reen_lock_word", fa_out, exp_a());

        // ---------------- reset mid-word ----------------
        send_a(4, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("async_reset_outs", {bus_a.locked, bus_a.deser_valid, bus_a.frame_err,
                                      bus_a.err_count, bus_a.deser_out}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_a();
        bus_a.frame_in = 1'b0;
        bus_a.data_in = '0;
        repeat (12) step(1);
        check_eq("post_reset_valids", fa_valid, 0);
        check_eq("post_reset_locked", bus_a.locked, 1'b0);

        // ---------------- early edge in ALIGN is not counted ----------------
        send_a(10, 1'b1);
        send_a(6, 1'b1);
        send_a(10, 1'b1);
        check_eq("align_err_pulses", fa_err, 0);
        check_eq("align_err_count", bus_a.err_count, 8'd0);
        for (int f = 0; f < 3; f++) send_a(10, 1'b1);
        send_a(10, 1'b1);
        check_eq("align_relock", fa_lk0, 1'b1);
        check_eq("align_relock_word", fa_out, exp_a());

        // ---------------- DUT B: 12-bit, LSB first ----------------
        bus_a.enable = 1'b0;
        bus_b.enable = 1'b1;
        wb = '{12'hABC, 12'h123};
        sum_v = 0;
        for (int f = 0; f < 4; f++) begin send_b(12, 1'b1); sum_v += fb_valid; end
        check_eq("b_prelock_valids", sum_v, 0);
        send_b(12, 1'b1);
        check_eq("b_lock", fb_lk0, 1'b1);
        check_eq("b_valids", fb_valid, 1);
        check_eq("b_pos", fb_vpos, 11);
        check_eq("b_word", fb_out, 24'h123ABC);
        wb = '{12'h5A3, 12'hF0F};
        send_b(12, 1'b1);
        check_eq("b_valids2", fb_valid, 1);
        check_eq("b_word2", fb_out, 24'hF0F5A3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_frame_deserializer.md
ADC_FRAME_DESERIALIZER -- requirements
Module: adc_frame_deserializer

Interface
REQ-001 SHALL provide parameter NUM_CH, default 4: number of serial ADC channels; legal range 1..16.
REQ-002 SHALL provide parameter BITS, default 10: bits per sample word; legal range 4..16.
REQ-003 SHALL provide parameter LOCK_FRAMES, default 4: consecutive correct frame edges needed to lock; legal range 1..15.
REQ-004 SHALL provide parameter MSB_FIRST, default 1: 1 = first serial bit is word MSB, 0 = first serial bit is word LSB.
REQ-005 SHALL have port data_clk, input, 1 bit: sole clock, one serial bit per channel per rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port data_in, input, NUM_CH bits: serial data, bit i = channel i.
REQ-008 SHALL have port frame_in, input, 1 bit: ADC frame signal, already synchronous to data_clk; its rising edge marks the first bit of a word.
REQ-009 SHALL have port enable, input, 1 bit: 0 = block idle.
REQ-010 SHALL have port deser_out, output, NUM_CH*BITS bits: channel i word on deser_out[i*BITS +: BITS].
REQ-011 SHALL have port deser_valid, output, 1 bit: one-cycle strobe, deser_out is new.
REQ-012 SHALL have port locked, output, 1 bit: high while in LOCKED.
REQ-013 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a framing error while LOCKED.
REQ-014 SHALL have port err_count, output, 8 bits: saturating count of LOCKED-state framing errors.

Function
REQ-015 SHALL register frame_in each cycle as frame_q; a frame edge is a cycle with frame_in=1 and frame_q=0.
REQ-016 SHALL shift data_in into a per-channel shift register every cycle while enable=1.
REQ-017 SHALL keep bit counter cnt (0..BITS-1): set to 0 on an accepted edge, otherwise increment, wrapping from BITS-1 to 0; an edge is expected on the wrap cycle.
REQ-018 SHALL implement states HUNT, ALIGN and LOCKED.
REQ-019 In HUNT, any edge SHALL move to ALIGN with cnt=0 and good_cnt=0.
REQ-020 In ALIGN, an edge on the expected cycle SHALL increment good_cnt; on reaching LOCK_FRAMES, the state SHALL move to LOCKED in that cycle.
REQ-021 In ALIGN or LOCKED, an edge on a non-expected cycle SHALL restart ALIGN, using that edge as the new word start (cnt=0, good_cnt=0).
REQ-022 In ALIGN or LOCKED, no edge on an expected cycle SHALL return the block to HUNT.
REQ-023 In LOCKED, on the cycle with cnt=BITS-1, deser_out SHALL load every channel's word, last bit included; deser_valid SHALL be high the following cycle only.
REQ-024 With MSB_FIRST=1, the bit sampled at cnt=0 SHALL land at word bit BITS-1; with MSB_FIRST=0, it SHALL land at bit 0.
REQ-025 The first valid word after lock SHALL be the word starting at the edge that caused entry to LOCKED; no words SHALL be output in HUNT or ALIGN.
REQ-026 Latency SHALL be: last bit sampled at edge k, so deser_out and deser_valid are visible in cycle k+1.
REQ-027 A word completed before a missing edge SHALL still be output; a partial word cut short by an early edge SHALL be discarded with no valid.
REQ-028 Each LOCKED-state error (REQ-021 or REQ-022) SHALL pulse frame_err for one cycle and increment err_count, saturating at 255; errors in ALIGN SHALL not be counted.
REQ-029 enable=0 SHALL force HUNT, clear good_cnt, and hold the shift registers; locked, deser_valid and frame_err SHALL be 0; deser_out and err_count SHALL hold.
REQ-030 locked SHALL be a registered decode of state LOCKED.

Reset
REQ-031 While reset is high, regardless of data_clk: state=HUNT, cnt=0, good_cnt=0, frame_q=1, shift registers=0, deser_out=0, deser_valid=0, locked=0, frame_err=0, err_count=0.
REQ-032 frame_in already high at reset release SHALL NOT count as an edge.
REQ-033 Reset asserted mid-word SHALL discard the partial word with no valid.

Verification
REQ-034 Default parameters; 10-cycle frame, edge first seen at cycle 0; channel A carries 0x2A5 MSB-first -> locked rises after the edge at cycle 40; deser_valid at cycle 50; deser_out[9:0]=0x2A5.
REQ-035 MSB_FIRST=0, BITS=12, NUM_CH=2; ch0=0xABC, ch1=0x123, sent LSB-first -> deser_out=0x123ABC with one valid per 12 cycles.
REQ-036 While LOCKED, one frame edge arrives 3 cycles early -> one frame_err pulse, err_count=1, locked low, no valid for the truncated word; relock after 4 good frames.
REQ-037 While LOCKED, frame_in held low -> last full word still valid, then frame_err pulse and HUNT.
REQ-038 Force 300 LOCKED errors -> err_count=255, stays 255.
REQ-039 Drop enable mid-word, and separately assert reset mid-word -> no valid, locked=0, all outputs at the REQ-029 or REQ-031 values.
